// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/accumulate sequencer.
//   - op codes for requests arriving on req_op
//   - sequencer state encoding
//   - small op-decode helpers used by the sequencer
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2
    } hilo_state_e;

    // Ops that need the iterative multiplier.
    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU);
    endfunction

    // Signed ops take magnitudes and fix the sign up after the multiply.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MADD);
    endfunction

    // Accumulating ops add the product into {hi,lo}.
    function automatic logic op_is_acc(input logic [2:0] op);
        return (op == OP_MADD) || (op == OP_MADDU);
    endfunction

endpackage

// File: rtl/hilo_mult_core.sv
// hilo_mult_core: iterative unsigned WIDTH x WIDTH shift-add multiplier.
//   Retires BITS_PER_CYCLE multiplier bits per cycle; takes N = WIDTH/BITS_PER_CYCLE
//   cycles after start. Product is final once count has stepped from 1 to 0.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operands, clear product, count <= N
//   a, b        multiplicand, multiplier (sampled on start)
//   count       iterations still to run (0 = idle / finished)
//   product     2*WIDTH-bit partial/final product
module hilo_mult_core #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    localparam int N             = WIDTH / BITS_PER_CYCLE,
    localparam int CW            = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [CW-1:0]        count,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] mcand_sh;   // multiplicand, pre-shifted to the current digit weight
    logic [WIDTH-1:0]   mplier;     // multiplier, low digit is the one being retired
    logic [2*WIDTH-1:0] partial;

    assign partial = mcand_sh * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};

    // NOTE: sequential state is assigned with non-blocking (<=) so every register
    // samples the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_sh <= '0;
            mplier   <= '0;
            product  <= '0;
            count    <= '0;
        end else if (start) begin
            mcand_sh <= {{WIDTH{1'b0}}, a};
            mplier   <= b;
            product  <= '0;
            count    <= CW'(N);
        end else if (count != '0) begin
            product  <= product + partial;
            mcand_sh <= mcand_sh << BITS_PER_CYCLE;
            mplier   <= mplier >> BITS_PER_CYCLE;
            count    <= count - CW'(1);
        end
    end

endmodule

// File: rtl/hilo_mac_sequencer.sv
// hilo_mac_sequencer: multi-cycle owner of the HI/LO pair for MULT/MULTU/MADD/MADDU/
//   MTHI/MTLO. Handshake in IDLE, iterative multiply in MUL, sign fix-up and
//   write/accumulate into HI/LO in ACC.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only in IDLE
//   req_op, req_a, req_b  op code and rs/rt operands, sampled at accept
//   flush                 abort an in-flight op (also drops a same-cycle accept)
//   busy                  high in MUL and ACC
//   done, err             registered one-cycle retire pulse; err flags an illegal op
//   hi, lo                HI/LO registers, always readable
module hilo_mac_sequencer
    import hilo_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    hilo_state_e        state_q, state_d;
    logic               sign_q;
    logic               acc_q;
    logic               accept;
    logic               start;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [2*WIDTH-1:0] acc_sum;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = req_valid && req_ready && !flush;
    assign start     = accept && op_is_mul(req_op);

    // Signed ops multiply magnitudes; 2^(W-1) negates to itself, which read as
    // unsigned is exactly the right magnitude.
    assign mag_a = (op_is_signed(req_op) && req_a[WIDTH-1]) ? -req_a : req_a;
    assign mag_b = (op_is_signed(req_op) && req_b[WIDTH-1]) ? -req_b : req_b;

    assign prod_fixed = sign_q ? -product : product;
    assign acc_sum    = {hi, lo} + prod_fixed;

    hilo_mult_core #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (mag_a),
        .b       (mag_b),
        .count   (count),
        .product (product)
    );

    // NOTE: state_d gets a default before the case so every path assigns it and no
    // latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)              state_d = ST_MUL;
            ST_MUL:  if (count == CW'(1))    state_d = ST_ACC;  // last digit retires this cycle
            ST_ACC:                          state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            acc_q  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state_q == ST_IDLE && accept) begin
                if (req_op == OP_MTHI) begin
                    hi   <= req_a;
                    done <= 1'b1;
                end else if (req_op == OP_MTLO) begin
                    lo   <= req_a;
                    done <= 1'b1;
                end else if (op_is_mul(req_op)) begin
                    sign_q <= op_is_signed(req_op) && (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
                    acc_q  <= op_is_acc(req_op);
                end else begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end
            end else if (state_q == ST_ACC && !flush) begin
                {hi, lo} <= acc_q ? acc_sum : prod_fixed;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hilo_mac_sequencer.sv
// Self-checking bench for hilo_mac_sequencer: directed cases plus random ops checked
// against an arithmetic model of HI/LO. A second instance runs 4 bits per cycle.
module tb_hilo_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, flush, busy, done, err;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b, hi, lo;

    logic        v4, rdy4, busy4, done4, err4;
    logic [2:0]  op4;
    logic [31:0] a4, b4, hi4, lo4;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;

    always #5 clk = ~clk;

    hilo_mac_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
        .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
    );

    hilo_mac_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(rdy4),
        .req_op(op4), .req_a(a4), .req_b(b4), .flush(1'b0),
        .busy(busy4), .done(done4), .err(err4), .hi(hi4), .lo(lo4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: HI/LO after an op, from the architectural definition.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 3'd0 || op == 3'd2) p = 64'(sa * sb);
        else                          p = {32'b0, a} * {32'b0, b};
        case (op)
            3'd0, 3'd1: {m_hi, m_lo} = p;
            3'd2, 3'd3: {m_hi, m_lo} = {m_hi, m_lo} + p;
            3'd4:       m_hi = a;
            3'd5:       m_lo = a;
            default:    ;
        endcase
    endtask

    // Issue one op, wait (bounded) for done, check latency, busy profile, err, HI/LO.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int   k;
        int   lat_exp;
        logic seen;
        lat_exp = (op <= 3'd3) ? 34 : 1;
        @(negedge clk);
        check({tag, " ready"}, 64'(req_ready), 64'd1);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) req_valid = 1'b0;
            if (done) seen = 1'b1;
            else if (k == 1 || k == lat_exp - 1) check({tag, " busy"}, 64'(busy), 64'd1);
        end
        model_apply(op, a, b);
        check({tag, " latency"}, 64'(k), 64'(lat_exp));
        check({tag, " err"}, 64'(err), 64'(op > 3'd5));
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(m_hi));
        check({tag, " lo"}, 64'(lo), 64'(m_lo));
    endtask

    initial begin
        int          k, d1, d2;
        logic [31:0] hi1, lo1;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; flush = 1'b0;
        v4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;

        // 4-bits-per-cycle instance: MULTU all-ones, retires at T+10.
        @(negedge clk);
        op4 = 3'd1; a4 = 32'hFFFF_FFFF; b4 = 32'hFFFF_FFFF; v4 = 1'b1;
        k = 0;
        while (!done4 && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) v4 = 1'b0;
        end
        check("bpc4 latency", 64'(k), 64'd10);
        check("bpc4 result", {hi4, lo4}, 64'hFFFF_FFFE_0000_0001);

        // Case 1: MULTU all-ones.
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
        check("multu max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // Case 2: signed products, including the most-negative operand.
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mult -3*7");
        check("mult -3*7 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, "mult minneg");
        check("mult minneg const", {hi, lo}, 64'h4000_0000_0000_0000);

        // Case 3: accumulate carry across LO/HI and signed accumulate.
        run_op(3'd4, 32'd0, 32'd0, "mthi");
        run_op(3'd5, 32'hFFFF_FFFF, 32'd0, "mtlo");
        run_op(3'd3, 32'd1, 32'd1, "maddu carry");
        check("maddu carry const", {hi, lo}, 64'h0000_0001_0000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd1, "madd -1");
        check("madd -1 const", {hi, lo}, 64'h0000_0000_FFFF_FFFF);

        // Case 6: illegal ops.
        run_op(3'd7, 32'h1234_5678, 32'd9, "op7");
        run_op(3'd6, 32'h0BAD_0BAD, 32'd3, "op6");

        // Random ops against the model.
        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            run_op(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop));
        end

        // Case 4: valid held through busy; second MULT accepted only when idle again.
        @(negedge clk);
        req_op = 3'd0; req_a = $urandom; req_b = $urandom; req_valid = 1'b1;
        model_apply(3'd0, req_a, req_b);
        hi1 = m_hi; lo1 = m_lo;
        k = 0; d1 = 0; d2 = 0;
        while (d2 == 0 && k < 150) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                req_a = $urandom; req_b = $urandom;
            end
            if (k == 33) check("held ready busy", 64'(req_ready), 64'd0);
            if (k == 35) req_valid = 1'b0;
            if (done && d1 == 0) begin
                d1 = k;
                check("held first hi", 64'(hi), 64'(hi1));
                check("held first lo", 64'(lo), 64'(lo1));
                check("held ready idle", 64'(req_ready), 64'd1);
                model_apply(3'd0, req_a, req_b);
            end else if (done) begin
                d2 = k;
            end
        end
        check("held first done", 64'(d1), 64'd34);
        check("held second done", 64'(d2), 64'd68);
        check("held second result", {hi, lo}, {m_hi, m_lo});

        // Case 5: flush mid-MADD leaves HI/LO alone and emits no done.
        run_op(3'd4, 32'd5, 32'd0, "mthi 5");
        run_op(3'd5, 32'd5, 32'd0, "mtlo 5");
        @(negedge clk);
        req_op = 3'd2; req_a = $urandom; req_b = $urandom; req_valid = 1'b1;
        d1 = 0;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            if (j == 1)  req_valid = 1'b0;
            if (done)    d1++;
            if (j == 10) flush = 1'b1;
            if (j == 11) begin
                flush = 1'b0;
                check("flush ready", 64'(req_ready), 64'd1);
                check("flush busy", 64'(busy), 64'd0);
            end
        end
        check("flush no done", 64'(d1), 64'd0);
        check("flush hilo", {hi, lo}, 64'h0000_0005_0000_0005);

        // rst_n mid-MUL clears HI/LO immediately.
        @(negedge clk);
        req_op = 3'd1; req_a = $urandom; req_b = $urandom; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd3, 32'd6, 32'd7, "after reset maddu");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
